fp_add_pipe: RTL and testbench

Parametrised, pipelined minifloat adder/subtractor and the successor to the team's single-stage 8-bit FP adder. It adds the generic-width format (default 1/4/3, bias 7), with a hidden bit, subnormals, infinity/NaN, round-to-nearest-even, an add/sub mode and a valid/ready stream interface. It sits between the operand register file and the result bus, and sustains one operation per cycle when not back-pressured.

---
 rtl/fp_add_pkg.sv | 41 ++++
 rtl/fp_add_pipe_if.sv | 29 ++
 rtl/fp_lzc.sv | 16 +
 rtl/fp_add_pipe.sv | 190 +++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_add_pkg.sv
// Shared helpers for the minifloat adder: field extraction, operand classification and
// canonical special encodings. Words are passed zero-extended to 32 bits with explicit widths.
package fp_add_pkg;

    typedef enum logic [2:0] {ClsZero, ClsSub, ClsNorm, ClsInf, ClsNan} fp_cls_e;

    function automatic logic fp_sign(input logic [31:0] w, input int unsigned ew,
                                     input int unsigned mw);
        return 1'((w >> (ew + mw)) & 32'd1);
    endfunction

    function automatic logic [31:0] fp_exp(input logic [31:0] w, input int unsigned ew,
                                           input int unsigned mw);
        return (w >> mw) & ((32'd1 << ew) - 32'd1);
    endfunction

    function automatic logic [31:0] fp_man(input logic [31:0] w, input int unsigned mw);
        return w & ((32'd1 << mw) - 32'd1);
    endfunction

    function automatic fp_cls_e fp_classify(input logic [31:0] w, input int unsigned ew,
                                            input int unsigned mw);
        logic [31:0] e;
        logic [31:0] m;
        e = fp_exp(w, ew, mw);
        m = fp_man(w, mw);
        if (e == (32'd1 << ew) - 32'd1) return (m == 32'd0) ? ClsInf : ClsNan;
        if (e == 32'd0) return (m == 32'd0) ? ClsZero : ClsSub;
        return ClsNorm;
    endfunction

    function automatic logic [31:0] fp_nan_word(input int unsigned ew, input int unsigned mw);
        return (32'd1 << (ew + mw)) - 32'd1;
    endfunction

    function automatic logic [31:0] fp_inf_word(input logic sign, input int unsigned ew,
                                                input int unsigned mw);
        return ({31'd0, sign} << (ew + mw)) | (((32'd1 << ew) - 32'd1) << mw);
    endfunction

endpackage

// File: rtl/fp_add_pipe_if.sv
// Operand/result stream bundle for fp_add_pipe; master drives operands, slave is the adder.
interface fp_add_pipe_if #(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAN_W = 3
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_ovf;
    logic         out_inexact;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_inexact
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_inexact
    );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);
    always_comb begin
        count = CNT_W'(WIDTH);
        // Scanning upward lets the most significant set bit win.
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (data[i]) count = CNT_W'(int'(WIDTH) - 1 - i);
        end
    end
endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage minifloat adder/subtractor (align, add, normalise/round) with a global stall.
// Specials are resolved at capture and bypass the arithmetic through the pipe.
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAN_W = 3
) (
    input logic          clk,
    input logic          rst,
    fp_add_pipe_if.slave bus
);
    localparam int unsigned W        = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W    = MAN_W + 1;
    localparam int unsigned ALN_W    = MAN_W + 4;
    localparam int unsigned SUM_W    = MAN_W + 5;
    localparam int unsigned PAD_W    = MAN_W + 3;
    localparam int unsigned SH_W     = SIG_W + PAD_W;
    localparam int unsigned LZ_W     = $clog2(ALN_W + 1);
    localparam int unsigned EXPN_W   = EXP_W + 1;
    localparam int unsigned EXP_ONES = (1 << EXP_W) - 1;

    logic             advance;
    logic [W-1:0]     a_w, b_w, lg_w, sm_w, sp_word;
    logic             a_sign, b_sign, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0] lg_e, sm_e, lg_eff, sm_eff, diff;
    logic [MAN_W-1:0] lg_m, sm_m;
    logic [SIG_W-1:0] sm_sig;
    logic [SH_W-1:0]  sh_out;
    logic [ALN_W-1:0] lg_aln, sm_aln;

    logic             s1_valid_q, s1_special_q, s1_sign_q, s1_sub_q;
    logic [W-1:0]     s1_sp_word_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [ALN_W-1:0] s1_lg_q, s1_sm_q;

    logic [SUM_W-1:0] sum;
    logic             sum_sign;
    logic             s2_valid_q, s2_special_q, s2_sign_q;
    logic [W-1:0]     s2_sp_word_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SUM_W-1:0] s2_sum_q;

    logic [LZ_W-1:0]   lz;
    logic [EXP_W-1:0]  lim;
    int unsigned       shamt;
    logic [ALN_W-1:0]  vec;
    logic [EXPN_W-1:0] exp_n, exp_f;
    logic              inc;
    logic [SIG_W:0]    sig_r;
    logic [SIG_W-1:0]  sig_f;
    logic [EXP_W-1:0]  exp_field;
    logic [W-1:0]      res_word;
    logic              res_ovf, res_inexact;

    logic              out_valid_q, out_ovf_q, out_inexact_q;
    logic [W-1:0]      out_sum_q;

    assign advance         = !out_valid_q | bus.out_ready;
    assign bus.in_ready    = advance;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sum     = out_sum_q;
    assign bus.out_ovf     = out_ovf_q;
    assign bus.out_inexact = out_inexact_q;

    // S1: classify, order by magnitude and align the smaller operand.
    always_comb begin
        a_w    = bus.in_a;
        b_w    = {bus.in_b[W-1] ^ bus.in_sub, bus.in_b[W-2:0]};
        a_sign = fp_sign(32'(a_w), EXP_W, MAN_W);
        b_sign = fp_sign(32'(b_w), EXP_W, MAN_W);
        a_inf  = fp_classify(32'(a_w), EXP_W, MAN_W) == ClsInf;
        b_inf  = fp_classify(32'(b_w), EXP_W, MAN_W) == ClsInf;
        a_nan  = fp_classify(32'(a_w), EXP_W, MAN_W) == ClsNan;
        b_nan  = fp_classify(32'(b_w), EXP_W, MAN_W) == ClsNan;
        if (b_w[W-2:0] > a_w[W-2:0]) begin
            lg_w = b_w;
            sm_w = a_w;
        end else begin
            lg_w = a_w;
            sm_w = b_w;
        end
        lg_e   = EXP_W'(fp_exp(32'(lg_w), EXP_W, MAN_W));
        sm_e   = EXP_W'(fp_exp(32'(sm_w), EXP_W, MAN_W));
        lg_m   = MAN_W'(fp_man(32'(lg_w), MAN_W));
        sm_m   = MAN_W'(fp_man(32'(sm_w), MAN_W));
        lg_eff = (lg_e == '0) ? EXP_W'(1) : lg_e;
        sm_eff = (sm_e == '0) ? EXP_W'(1) : sm_e;
        diff   = lg_eff - sm_eff;
        sm_sig = {sm_e != '0, sm_m};
        lg_aln = {lg_e != '0, lg_m, 3'b000};
        sh_out = {sm_sig, {PAD_W{1'b0}}} >> diff;
        if (32'(diff) >= PAD_W) sm_aln = {{(ALN_W - 1){1'b0}}, |sm_sig};
        else sm_aln = {sh_out[SH_W-1 -: SIG_W+2], |sh_out[MAN_W:0]};
        if (a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign))) begin
            sp_word = W'(fp_nan_word(EXP_W, MAN_W));
        end else begin
            sp_word = W'(fp_inf_word(a_inf ? a_sign : b_sign, EXP_W, MAN_W));
        end
    end

    // S2: magnitude add/subtract; an exact cancellation is forced to +0.
    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_lg_q} - {1'b0, s1_sm_q})
                       : ({1'b0, s1_lg_q} + {1'b0, s1_sm_q});
        sum_sign = (sum == '0 && s1_sub_q) ? 1'b0 : s1_sign_q;
    end

    fp_lzc #(
        .WIDTH(ALN_W),
        .CNT_W(LZ_W)
    ) u_lzc (
        .data (s2_sum_q[ALN_W-1:0]),
        .count(lz)
    );

    // S3: normalise (left shift capped so the exponent stays >= 1), then round to nearest even.
    always_comb begin
        lim   = s2_exp_q - EXP_W'(1);
        shamt = (32'(lz) > 32'(lim)) ? 32'(lim) : 32'(lz);
        if (s2_sum_q[SUM_W-1]) begin
            vec   = {s2_sum_q[SUM_W-1:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = {1'b0, s2_exp_q} + EXPN_W'(1);
        end else begin
            vec   = s2_sum_q[ALN_W-1:0] << shamt;
            exp_n = {1'b0, s2_exp_q} - EXPN_W'(shamt);
        end
        inc       = vec[2] & (vec[1] | vec[0] | vec[3]);
        sig_r     = {1'b0, vec[ALN_W-1:3]} + {{SIG_W{1'b0}}, inc};
        sig_f     = sig_r[SIG_W] ? sig_r[SIG_W:1] : sig_r[SIG_W-1:0];
        exp_f     = sig_r[SIG_W] ? exp_n + EXPN_W'(1) : exp_n;
        exp_field = sig_f[SIG_W-1] ? exp_f[EXP_W-1:0] : '0;
        res_word    = {s2_sign_q, exp_field, sig_f[MAN_W-1:0]};
        res_ovf     = 1'b0;
        res_inexact = |vec[2:0];
        if (32'(exp_f) >= EXP_ONES) begin
            res_word    = W'(fp_inf_word(s2_sign_q, EXP_W, MAN_W));
            res_ovf     = 1'b1;
            res_inexact = 1'b1;
        end
        if (s2_special_q) begin
            res_word    = s2_sp_word_q;
            res_ovf     = 1'b0;
            res_inexact = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_special_q  <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_sp_word_q  <= '0;
            s1_exp_q      <= '0;
            s1_lg_q       <= '0;
            s1_sm_q       <= '0;
            s2_valid_q    <= 1'b0;
            s2_special_q  <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_sp_word_q  <= '0;
            s2_exp_q      <= '0;
            s2_sum_q      <= '0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_ovf_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q    <= bus.in_valid;
            s1_special_q  <= a_nan | b_nan | a_inf | b_inf;
            s1_sign_q     <= lg_w[W-1];
            s1_sub_q      <= a_sign ^ b_sign;
            s1_sp_word_q  <= sp_word;
            s1_exp_q      <= lg_eff;
            s1_lg_q       <= lg_aln;
            s1_sm_q       <= sm_aln;
            s2_valid_q    <= s1_valid_q;
            s2_special_q  <= s1_special_q;
            s2_sign_q     <= sum_sign;
            s2_sp_word_q  <= s1_sp_word_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= sum;
            out_valid_q   <= s2_valid_q;
            out_sum_q     <= res_word;
            out_ovf_q     <= res_ovf;
            out_inexact_q <= res_inexact;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe (1/4/3 format): directed corner cases, then a
// back-pressured random stream with a mid-stream reset, checked against an exact-value model.
module tb_fp_add_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_add_pipe_if #(.EXP_W(4), .MAN_W(3)) bus ();

    fp_add_pipe #(.EXP_W(4), .MAN_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value in units of the smallest subnormal (2^-9).
    function automatic int mag_of(input logic [7:0] w);
        int e;
        int m;
        e = int'(w[6:3]);
        m = int'(w[2:0]);
        return (e == 0) ? m : ((8 + m) << (e - 1));
    endfunction

    // Returns {ovf, inexact, sum}.
    function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic sub);
        logic [7:0] bb;
        logic a_nan, b_nan, a_inf, b_inf, sign;
        int s, mag, p, shift, mant, rem, half, e;
        bb    = {b[7] ^ sub, b[6:0]};
        a_nan = (a[6:3] == 4'hF) && (a[2:0] != 3'd0);
        b_nan = (bb[6:3] == 4'hF) && (bb[2:0] != 3'd0);
        a_inf = (a[6:3] == 4'hF) && (a[2:0] == 3'd0);
        b_inf = (bb[6:3] == 4'hF) && (bb[2:0] == 3'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[7] != bb[7]))) return {2'b00, 8'h7F};
        if (a_inf) return {2'b00, a[7], 7'h78};
        if (b_inf) return {2'b00, bb[7], 7'h78};
        s = (a[7] ? -mag_of(a) : mag_of(a)) + (bb[7] ? -mag_of(bb) : mag_of(bb));
        if (s == 0) return {2'b00, a[7] & bb[7], 7'h00};
        sign = (s < 0);
        mag  = sign ? -s : s;
        if (mag < 8) return {2'b00, sign, 4'h0, 3'(mag)};
        p = 3;
        while ((mag >> (p + 1)) != 0) p++;
        shift = p - 3;
        mant  = mag >> shift;
        rem   = mag - (mant << shift);
        half  = (shift > 0) ? (1 << (shift - 1)) : 0;
        if (shift > 0 && (rem > half || (rem == half && (mant % 2) == 1))) mant++;
        if (mant == 16) begin
            mant = 8;
            shift++;
        end
        e = shift + 1;
        if (e >= 15) return {2'b11, sign, 7'h78};
        return {1'b0, rem != 0, sign, 4'(e), 3'(mant - 8)};
    endfunction

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] e_sum, input logic e_ovf,
                         input logic e_inx);
        int n;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_sub   = ~sub;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'd3);
        chk({tag, " sum"}, 32'(bus.out_sum), 32'(e_sum));
        chk({tag, " ovf"}, 32'(bus.out_ovf), 32'(e_ovf));
        chk({tag, " inexact"}, 32'(bus.out_inexact), 32'(e_inx));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] q[$];
        logic [9:0] exp_res;
        logic [9:0] held;
        int captured;
        int budget;
        bit did_rst;
        bit prev_stall;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_sum", 32'(bus.out_sum), 32'd0);
        chk("reset out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("reset out_inexact", 32'(bus.out_inexact), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op("1+1", 8'h38, 8'h38, 1'b0, 8'h40, 1'b0, 1'b0);
        do_op("1-1", 8'h38, 8'h38, 1'b1, 8'h00, 1'b0, 1'b0);
        do_op("-0+-0", 8'h80, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0);
        do_op("tie even", 8'h38, 8'h18, 1'b0, 8'h38, 1'b0, 1'b1);
        do_op("tie odd", 8'h39, 8'h18, 1'b0, 8'h3A, 1'b0, 1'b1);
        do_op("overflow", 8'h77, 8'h77, 1'b0, 8'h78, 1'b1, 1'b1);
        do_op("inf-inf", 8'h78, 8'hF8, 1'b0, 8'h7F, 1'b0, 1'b0);
        do_op("inf+1", 8'h78, 8'h38, 1'b0, 8'h78, 1'b0, 1'b0);
        do_op("sub+sub", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        do_op("norm-sub", 8'h08, 8'h01, 1'b1, 8'h07, 1'b0, 1'b0);

        captured   = 0;
        budget     = 0;
        did_rst    = 1'b0;
        prev_stall = 1'b0;
        held       = '0;
        while ((captured < 20 || q.size() != 0) && budget < 2000) begin
            budget++;
            if (prev_stall) begin
                chk("stall valid", 32'(bus.out_valid), 32'd1);
                chk("stall hold", 32'({bus.out_ovf, bus.out_inexact, bus.out_sum}), 32'(held));
            end
            if (!did_rst && captured == 8) begin
                bus.in_valid = 1'b0;
                rst = 1'b1;
                #1;
                chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
                chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
                q.delete();
                prev_stall = 1'b0;
                did_rst    = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                continue;
            end
            bus.out_ready = ($urandom_range(0, 99) >= 40);
            if (captured < 20) begin
                bus.in_valid = 1'b1;
                bus.in_a     = 8'($urandom);
                bus.in_b     = 8'($urandom);
                bus.in_sub   = 1'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("stream extra result", 32'(bus.out_valid), 32'd0);
                end else begin
                    exp_res = q.pop_front();
                    chk("stream result", 32'({bus.out_ovf, bus.out_inexact, bus.out_sum}),
                        32'(exp_res));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_add(bus.in_a, bus.in_b, bus.in_sub));
                captured++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = {bus.out_ovf, bus.out_inexact, bus.out_sum};
            @(posedge clk);
            #1;
        end
        chk("stream captured", 32'(captured), 32'd20);
        chk("stream drained", 32'(q.size()), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stream idle", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
